tlc_call_detector: RTL
======================

Name: tlc_call_detector

Overview:
- Vehicle-detection front end for the highway/farm traffic-light controller.
- Conditions the raw farm-road loop sensor and produces the latched sensor request `call`, which drives the controller's sensor input C.
- Reads the controller's farm light output back to learn when the call has been served, then withdraws the call.
- Also provides a saturating vehicle count and a fail-safe fault detector.

Parameters:
- DEBOUNCE_CYC, 4: consecutive enabled cycles a synchronized sample must differ from the debounced value before the debounced value flips.
- MIN_PRESENCE, 3: enabled cycles of continuous debounced presence required before a call is raised.
- STUCK_CYC, 200: enabled cycles of continuous debounced presence, outside SERVED, that declare the sensor stuck.
- CNT_W, 8: width of the vehicle counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  clock enable; all counters and state advance only when ena=1
- loop_raw  input  1  asynchronous loop-detector output, 1 = vehicle present
- farm_light  input  3  controller farm light, one-hot: 100=red, 010=yellow, 001=green
- clr_cnt  input  1  synchronous clear of veh_count, effective when ena=1
- call  output  1  request to controller (its C input)
- presence  output  1  debounced vehicle presence
- veh_count  output  CNT_W  saturating count of debounced presence rising edges
- fault  output  1  sticky sensor/interface fault

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: call=0, presence=0, veh_count=0, fault=0.
  - Internal: state=IDLE, all counters=0, synchronizer flops=0.
  - Reset asserted mid-operation aborts any pending call immediately.
- Synchronizer:
  - Two flops on loop_raw, clocked every cycle regardless of ena.
  - sync_q is the second flop.
- Debounce (when ena=1):
  - If sync_q != presence, increment the mismatch counter; otherwise clear it.
  - When the counter reaches DEBOUNCE_CYC, toggle presence and clear the counter.
  - Any glitch shorter than DEBOUNCE_CYC cycles is fully rejected.
- Vehicle count:
  - A rising edge of presence increments veh_count; it saturates at all-ones and never wraps.
  - If clr_cnt and a rising edge occur in the same cycle, clr_cnt wins and the result is 0.
- State machine (states IDLE, ARMED, CALL, SERVED, FAULT; transitions only when ena=1):
  - IDLE: if presence=1, go to ARMED and set the presence counter to 1.
  - ARMED:
    - presence=0 → IDLE.
    - Presence counter reaches MIN_PRESENCE → CALL.
    - Otherwise increment the presence counter.
  - CALL: call=1, held regardless of presence (the vehicle may have stopped past the loop). farm_light=001 → SERVED.
  - SERVED:
    - call=0.
    - A presence rising edge while farm_light=010 sets the late flag.
    - farm_light=100 → CALL if the late flag is set or presence=1, else IDLE; clear the late flag on exit.
  - FAULT: call=1 permanently (fail-safe recall). Exit only by reset.
- Latency (defaults, ena=1 throughout):
  - loop_raw first sampled high at edge 0 → presence=1 after edge 5.
  - call=1 after edge 8 (1+DEBOUNCE_CYC+MIN_PRESENCE).
  - call falls on the edge after farm_light=001 is first sampled.
- Fault detection (any state except FAULT):
  - Stuck counter: increments each ena cycle with presence=1 while the state is not SERVED; clears when presence=0 or on entering SERVED. Reaching STUCK_CYC → fault=1, FAULT.
  - Illegal farm_light: any value other than 100/010/001 sampled with ena=1 → fault=1, FAULT on that edge.
  - Stuck and illegal-light conditions in the same cycle produce a single entry to FAULT.
- ena=0 freezes state, counters, presence and all outputs; the synchronizer continues to run.

Test Plan:
- Basic call: farm_light=100; loop_raw 0→1 held → presence=1 at edge 5, call=1 at edge 8, veh_count=1. Drive farm_light=001 → call=0 next edge. Return farm_light=100 with loop_raw=0 → IDLE, call stays 0.
- Glitch rejection: loop_raw pulsed high for 3 cycles, repeated 5 times with 10-cycle gaps → presence, call and veh_count remain 0.
- Late arrival: while in SERVED with farm_light=010, a vehicle arrives then leaves → on farm_light=100, call=1 on the next edge.
- Stuck sensor: STUCK_CYC=20, loop_raw held 1, farm_light held 100 → fault=1 and call=1 at the 20th presence cycle. Then loop_raw=0 → fault and call stay 1 until rst_n pulse, after which all outputs are 0.
- Illegal light: farm_light=011 for one cycle during ARMED → fault=1 next edge, call=1. With ena=0 the same value has no effect.
- Count and reset: 260 debounced vehicles → veh_count=255 (saturates). clr_cnt coincident with a rising edge → 0. rst_n asserted while call=1 → call=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/tlc_call_detector.sv
// Farm-road loop conditioner: synchronizes and debounces the loop sensor, raises/withdraws call, counts vehicles, detects faults.
// Latency: presence 5 enabled edges after loop_raw is first sampled high; call 3 edges after presence (8 total).
// Backpressure: none; ena=0 stalls everything except the input synchronizer, and outputs hold their last value.
module tlc_call_detector #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int MIN_PRESENCE = 3,
  parameter int STUCK_CYC    = 200,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             loop_raw,
  input  logic [2:0]       farm_light,
  input  logic             clr_cnt,
  output logic             call,
  output logic             presence,
  output logic [CNT_W-1:0] veh_count,
  output logic             fault
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int PR_W = $clog2(MIN_PRESENCE + 1);
  localparam int ST_W = $clog2(STUCK_CYC + 1);

  // Counters fire on the cycle whose increment would reach the threshold.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PR_W-1:0] PR_LAST = PR_W'(MIN_PRESENCE - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STUCK_CYC - 1);

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CALL,
    S_SERVED,
    S_FAULT
  } state_t;

  logic             r_sync1;
  logic             r_sync_q;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_presence;
  logic [CNT_W-1:0] r_veh_cnt;
  state_t           r_state;
  logic [PR_W-1:0]  r_pcnt;
  logic             r_late;
  logic [ST_W-1:0]  r_stuck;

  logic             w_mismatch;
  logic             w_db_flip;
  logic             w_rise;
  logic             w_light_bad;
  logic             w_stuck_hit;
  logic             w_entering_served;
  state_t           w_state_nxt;
  logic [PR_W-1:0]  w_pcnt_nxt;
  logic             w_late_nxt;
  logic [ST_W-1:0]  w_stuck_nxt;
  logic             w_call;
  logic             w_fault;

  // Two-flop synchronizer on the asynchronous loop input; runs even when ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync1  <= loop_raw;
      r_sync_q <= r_sync1;
    end
  end

  // Debounce decode: a flip needs DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    w_mismatch = (r_sync_q != r_presence);
    w_db_flip  = w_mismatch && (r_db_cnt >= DB_LAST);
    w_rise     = w_db_flip && !r_presence;
  end

  // Debounce counter and the debounced presence flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt   <= '0;
      r_presence <= 1'b0;
    end else if (ena) begin
      if (!w_mismatch) begin
        r_db_cnt <= '0;
      end else if (w_db_flip) begin
        r_db_cnt   <= '0;
        r_presence <= ~r_presence;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Saturating vehicle counter; a clear beats a coincident rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_veh_cnt <= '0;
    end else if (ena) begin
      if (clr_cnt) begin
        r_veh_cnt <= '0;
      end else if (w_rise && (r_veh_cnt != {CNT_W{1'b1}})) begin
        r_veh_cnt <= r_veh_cnt + CNT_W'(1);
      end
    end
  end

  // Fault conditions; the light is only meaningful when ena qualifies it at the register.
  always_comb begin
    w_light_bad = !((farm_light == LIGHT_RED) ||
                    (farm_light == LIGHT_YELLOW) ||
                    (farm_light == LIGHT_GREEN));
    w_stuck_hit = r_presence && (r_state != S_SERVED) && (r_state != S_FAULT) &&
                  (r_stuck >= ST_LAST);
  end

  // Next-state and output decode; fault entry overrides any normal transition.
  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_late_nxt  = r_late;
    w_call      = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_presence) begin
          w_state_nxt = S_ARMED;
          w_pcnt_nxt  = PR_W'(1);
        end
      end
      S_ARMED: begin
        if (!r_presence) begin
          w_state_nxt = S_IDLE;
        end else if (r_pcnt >= PR_LAST) begin
          w_state_nxt = S_CALL;
        end else begin
          w_pcnt_nxt = r_pcnt + PR_W'(1);
        end
      end
      S_CALL: begin
        // Held regardless of presence: the vehicle may have rolled past the loop.
        w_call = 1'b1;
        if (farm_light == LIGHT_GREEN) begin
          w_state_nxt = S_SERVED;
        end
      end
      S_SERVED: begin
        // A car arriving on yellow would otherwise be stranded at red.
        if (w_rise && (farm_light == LIGHT_YELLOW)) begin
          w_late_nxt = 1'b1;
        end
        if (farm_light == LIGHT_RED) begin
          w_state_nxt = (r_late || r_presence) ? S_CALL : S_IDLE;
          w_late_nxt  = 1'b0;
        end
      end
      S_FAULT: begin
        // Fail-safe recall: keep requesting service until reset.
        w_call  = 1'b1;
        w_fault = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if ((r_state != S_FAULT) && (w_light_bad || w_stuck_hit)) begin
      w_state_nxt = S_FAULT;
    end
  end

  // Stuck-sensor run length: presence outside SERVED, reset by absence or on being served.
  always_comb begin
    w_entering_served = (w_state_nxt == S_SERVED) && (r_state != S_SERVED);
    w_stuck_nxt       = r_stuck;
    if (!r_presence || w_entering_served) begin
      w_stuck_nxt = '0;
    end else if ((r_state != S_SERVED) && (r_state != S_FAULT) && (r_stuck < ST_LAST)) begin
      w_stuck_nxt = r_stuck + ST_W'(1);
    end
  end

  // State register and the FSM-owned counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pcnt  <= '0;
      r_late  <= 1'b0;
      r_stuck <= '0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_late  <= w_late_nxt;
      r_stuck <= w_stuck_nxt;
    end
  end

  // Outputs decode directly from reset-cleared state, so reset drops call immediately.
  always_comb begin
    call      = w_call;
    fault     = w_fault;
    presence  = r_presence;
    veh_count = r_veh_cnt;
  end

endmodule
